// File: rtl/tlc_pkg.sv
// Shared encodings and default timings for the intersection phase scheduler.
package tlc_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED = 3'd0,
    ST_LEFT    = 3'd1,
    ST_GREEN   = 3'd2,
    ST_YELLOW  = 3'd3,
    ST_PED     = 3'd4
  } tlc_state_e;

  localparam logic [1:0] RD_A = 2'd0;
  localparam logic [1:0] RD_B = 2'd1;
  localparam logic [1:0] RD_C = 2'd2;

  localparam int unsigned L_TIME_DEF  = 2;
  localparam int unsigned G_TIME_DEF  = 4;
  localparam int unsigned Y_TIME_DEF  = 1;
  localparam int unsigned AR_TIME_DEF = 1;
  localparam int unsigned P_TIME_DEF  = 3;
  localparam int unsigned CW_DEF      = 4;

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin selector: first pending road strictly after cur, in A->B->C->A order.
module tlc_rr_pick
  import tlc_pkg::*;
(
  input  logic [2:0] pend,
  input  logic [1:0] cur,
  output logic [1:0] next_cur,
  output logic       any
);

  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    any      = |pend;
    next_cur = cur;
    w_idx    = RD_A;
    w_found  = 1'b0;
    // cur itself is visited last, so a road pending again waits for the others
    for (int unsigned k = 1; k <= 3; k++) begin
      w_idx = 2'((32'(cur) + k) % 32'd3);
      if (!w_found && pend[w_idx]) begin
        next_cur = w_idx;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Three-road light phase scheduler with round-robin grants and a pedestrian walk phase.
// Optional macro TLC_PED_COUNTDOWN_EN adds the PED_CNT walk countdown output.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int unsigned L_TIME  = L_TIME_DEF,
  parameter int unsigned G_TIME  = G_TIME_DEF,
  parameter int unsigned Y_TIME  = Y_TIME_DEF,
  parameter int unsigned AR_TIME = AR_TIME_DEF,
  parameter int unsigned P_TIME  = P_TIME_DEF,
  parameter int unsigned CW      = CW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ENABLE,
  input  logic [2:0]    REQ,
  input  logic          PED_L,
  input  logic          PED_R,
  output logic          GA,
  output logic          YA,
  output logic          RA,
  output logic          LA,
  output logic          GB,
  output logic          YB,
  output logic          RB,
  output logic          LB,
  output logic          GC,
  output logic          YC,
  output logic          RC,
  output logic          LC,
  output logic          RL,
  output logic          GL,
  output logic          RR,
  output logic          GR,
  output logic [2:0]    PHASE
`ifdef TLC_PED_COUNTDOWN_EN
  ,
  output logic [CW-1:0] PED_CNT
`endif
);

  localparam logic [CW-1:0] T_L  = CW'(L_TIME - 1);
  localparam logic [CW-1:0] T_G  = CW'(G_TIME - 1);
  localparam logic [CW-1:0] T_Y  = CW'(Y_TIME - 1);
  localparam logic [CW-1:0] T_AR = CW'(AR_TIME - 1);
  localparam logic [CW-1:0] T_P  = CW'(P_TIME - 1);

  tlc_state_e    r_state, w_state_nxt;
  logic [1:0]    r_cur, w_cur_nxt;
  logic [CW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_pend, w_pend_nxt;
  logic          r_pl, r_pr, w_pl_nxt, w_pr_nxt;
  logic [2:0]    r_g, r_y, r_r, r_l;
  logic [2:0]    w_g, w_y, w_r, w_l, w_sel;
  logic          r_gl, r_gr, w_gl, w_gr;
  logic          w_enter_left, w_leave_ped;
  logic [1:0]    w_pick;
  logic          w_any;

  tlc_rr_pick u_pick (
    .pend     (r_pend),
    .cur      (r_cur),
    .next_cur (w_pick),
    .any      (w_any)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cur_nxt    = r_cur;
    w_timer_nxt  = r_timer;
    w_enter_left = 1'b0;
    w_leave_ped  = 1'b0;
    if (ENABLE) begin
      if (r_timer != '0) begin
        w_timer_nxt = r_timer - CW'(1);
      end else begin
        unique case (r_state)
          ST_ALL_RED: begin
            if (r_pl || r_pr) begin
              w_state_nxt = ST_PED;
              w_timer_nxt = T_P;
            end else if (w_any) begin
              w_state_nxt  = ST_LEFT;
              w_cur_nxt    = w_pick;
              w_timer_nxt  = T_L;
              w_enter_left = 1'b1;
            end else begin
              w_timer_nxt = T_AR;
            end
          end
          ST_LEFT: begin
            w_state_nxt = ST_GREEN;
            w_timer_nxt = T_G;
          end
          ST_GREEN: begin
            w_state_nxt = ST_YELLOW;
            w_timer_nxt = T_Y;
          end
          ST_YELLOW: begin
            w_state_nxt = ST_ALL_RED;
            w_timer_nxt = T_AR;
          end
          ST_PED: begin
            w_state_nxt = ST_ALL_RED;
            w_timer_nxt = T_AR;
            w_leave_ped = 1'b1;
          end
          default: begin
            w_state_nxt = ST_ALL_RED;
            w_timer_nxt = T_AR;
          end
        endcase
      end
    end
  end

  // Demand latches every cycle; a new request in the clearing cycle survives.
  always_comb begin
    w_sel      = 3'b001 << w_cur_nxt;
    w_pend_nxt = (r_pend & ~(w_enter_left ? w_sel : 3'b000)) | REQ;
    w_pl_nxt   = (r_pl & ~w_leave_ped) | PED_L;
    w_pr_nxt   = (r_pr & ~w_leave_ped) | PED_R;
  end

  // Lights are decoded from the next-state values so the registers line up with r_state.
  always_comb begin
    w_g  = '0;
    w_y  = '0;
    w_l  = '0;
    w_r  = '1;
    w_gl = 1'b0;
    w_gr = 1'b0;
    unique case (w_state_nxt)
      ST_LEFT:   w_l = w_sel;
      ST_GREEN: begin
        w_g = w_sel;
        w_r = ~w_sel;
      end
      ST_YELLOW: begin
        w_y = w_sel;
        w_r = ~w_sel;
      end
      ST_PED: begin
        w_gl = w_pl_nxt;
        w_gr = w_pr_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_ALL_RED;
      r_cur   <= RD_C;
      r_timer <= T_AR;
      r_pend  <= '0;
      r_pl    <= 1'b0;
      r_pr    <= 1'b0;
      r_g     <= '0;
      r_y     <= '0;
      r_l     <= '0;
      r_r     <= '1;
      r_gl    <= 1'b0;
      r_gr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_timer <= w_timer_nxt;
      r_pend  <= w_pend_nxt;
      r_pl    <= w_pl_nxt;
      r_pr    <= w_pr_nxt;
      r_g     <= w_g;
      r_y     <= w_y;
      r_l     <= w_l;
      r_r     <= w_r;
      r_gl    <= w_gl;
      r_gr    <= w_gr;
    end
  end

`ifdef TLC_PED_COUNTDOWN_EN
  logic [CW-1:0] r_ped_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_ped_cnt <= '0;
    end else begin
      r_ped_cnt <= (w_state_nxt == ST_PED) ? w_timer_nxt : '0;
    end
  end

  assign PED_CNT = r_ped_cnt;
`endif

  assign {GA, GB, GC} = {r_g[0], r_g[1], r_g[2]};
  assign {YA, YB, YC} = {r_y[0], r_y[1], r_y[2]};
  assign {RA, RB, RC} = {r_r[0], r_r[1], r_r[2]};
  assign {LA, LB, LC} = {r_l[0], r_l[1], r_l[2]};
  assign GL    = r_gl;
  assign GR    = r_gr;
  assign RL    = ~r_gl;
  assign RR    = ~r_gr;
  assign PHASE = r_state;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Randomized bench for tlc_phase_scheduler against a tick-count phase model.
module tb_tlc_phase_scheduler;

  localparam int L_T  = 2;
  localparam int G_T  = 4;
  localparam int Y_T  = 1;
  localparam int AR_T = 1;
  localparam int P_T  = 3;
  localparam int CW   = 4;

  localparam logic [18:0] RESET_VEC = 19'b000_0010_0010_0010_1010;

  logic       CLK = 1'b0;
  logic       RESET, ENABLE, PED_L, PED_R;
  logic [2:0] REQ;
  logic       GA, YA, RA, LA, GB, YB, RB, LB, GC, YC, RC, LC;
  logic       RL, GL, RR, GR;
  logic [2:0] PHASE;
`ifdef TLC_PED_COUNTDOWN_EN
  logic [CW-1:0] PED_CNT;
`endif

  tlc_phase_scheduler #(
    .L_TIME (L_T),
    .G_TIME (G_T),
    .Y_TIME (Y_T),
    .AR_TIME(AR_T),
    .P_TIME (P_T),
    .CW     (CW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .REQ(REQ),
    .PED_L(PED_L), .PED_R(PED_R),
    .GA(GA), .YA(YA), .RA(RA), .LA(LA),
    .GB(GB), .YB(YB), .RB(RB), .LB(LB),
    .GC(GC), .YC(YC), .RC(RC), .LC(LC),
    .RL(RL), .GL(GL), .RR(RR), .GR(GR),
    .PHASE(PHASE)
`ifdef TLC_PED_COUNTDOWN_EN
    , .PED_CNT(PED_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: phase number, enabled ticks remaining in it, served road, latches.
  int       m_phase, m_rem, m_cur;
  bit [2:0] m_pend;
  bit       m_pl, m_pr;

  function automatic int dur(input int ph);
    case (ph)
      1:       return L_T;
      2:       return G_T;
      3:       return Y_T;
      4:       return P_T;
      default: return AR_T;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = 0; m_rem = AR_T; m_cur = 2; m_pend = '0; m_pl = 0; m_pr = 0;
  endtask

  task automatic model_step(input bit en, input bit [2:0] req, input bit pl, input bit pr);
    bit granted  = 0;
    bit ped_done = 0;
    if (en) begin
      m_rem--;
      if (m_rem == 0) begin
        case (m_phase)
          0: begin
            if (m_pl || m_pr) m_phase = 4;
            else begin
              for (int k = 1; k <= 3; k++) begin
                int rd = (m_cur + k) % 3;
                if (!granted && m_pend[rd]) begin
                  m_cur = rd;
                  granted = 1;
                end
              end
              if (granted) m_phase = 1;
            end
          end
          1: m_phase = 2;
          2: m_phase = 3;
          3: m_phase = 0;
          default: begin m_phase = 0; ped_done = 1; end
        endcase
        m_rem = dur(m_phase);
      end
    end
    if (granted) m_pend[m_cur] = 1'b0;
    m_pend = m_pend | req;
    if (ped_done) begin m_pl = 0; m_pr = 0; end
    m_pl = m_pl | pl;
    m_pr = m_pr | pr;
  endtask

  function automatic logic [18:0] exp_vec();
    logic [15:0] v;
    logic g, y, l, gl, gr;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      g = (m_phase == 2) && (m_cur == i);
      y = (m_phase == 3) && (m_cur == i);
      l = (m_phase == 1) && (m_cur == i);
      v[15-4*i -: 4] = {g, y, !(g || y), l};
    end
    gl = (m_phase == 4) && m_pl;
    gr = (m_phase == 4) && m_pr;
    v[3:0] = {!gl, gl, !gr, gr};
    return {3'(m_phase), v};
  endfunction

  function automatic logic [18:0] dut_vec();
    return {PHASE, GA, YA, RA, LA, GB, YB, RB, LB, GC, YC, RC, LC, RL, GL, RR, GR};
  endfunction

  // Called at a falling edge: drive, take the rising edge, check at the next falling edge.
  task automatic cycle(input bit en, input bit [2:0] req, input bit pl, input bit pr, input string tag);
    ENABLE = en; REQ = req; PED_L = pl; PED_R = pr;
    @(posedge CLK);
    model_step(en, req, pl, pr);
    @(negedge CLK);
    chk(tag, 32'(dut_vec()), 32'(exp_vec()));
`ifdef TLC_PED_COUNTDOWN_EN
    chk({tag, "_pedcnt"}, 32'(PED_CNT), (m_phase == 4) ? 32'(m_rem - 1) : 32'd0);
`endif
  endtask

  initial begin
    RESET = 1'b0; ENABLE = 1'b0; REQ = '0; PED_L = 1'b0; PED_R = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("reset_vec", 32'(dut_vec()), 32'(RESET_VEC));
`ifdef TLC_PED_COUNTDOWN_EN
    chk("reset_pedcnt", 32'(PED_CNT), 32'd0);
`endif
    RESET = 1'b1;

    repeat (20) cycle(1, 3'b000, 0, 0, "idle");
    chk("idle_phase", 32'(PHASE), 32'd0);

    cycle(1, 3'b001, 0, 0, "reqA");
    repeat (14) cycle(1, 3'b000, 0, 0, "reqA_run");

    repeat (45) cycle(1, 3'b111, 0, 0, "all_req");
    repeat (10) cycle(1, 3'b000, 0, 0, "drain");

    cycle(1, 3'b001, 0, 0, "pedr_req");
    for (int i = 0; i < 40 && !(m_phase == 2 && m_cur == 0); i++) cycle(1, 3'b000, 0, 0, "to_greenA");
    chk("greenA_lit", 32'(GA), 32'd1);
    cycle(1, 3'b010, 0, 1, "pedr_press");
    repeat (20) cycle(1, 3'b000, 0, 0, "pedr_run");

    cycle(1, 3'b001, 0, 0, "en_req");
    for (int i = 0; i < 40; i++)
      cycle(i % 2 == 0, (i == 5) ? 3'b100 : 3'b000, 0, 0, "en_toggle");
    repeat (30) cycle(1, 3'b000, 0, 0, "en_drain");

    cycle(1, 3'b000, 1, 0, "pedl_press");
    repeat (12) cycle(1, 3'b000, 0, 0, "pedl_run");

    cycle(1, 3'b010, 0, 0, "rst_req");
    for (int i = 0; i < 40 && !(m_phase == 2 && m_cur == 1); i++) cycle(1, 3'b000, 0, 0, "to_greenB");
    chk("greenB_lit", 32'(GB), 32'd1);
    REQ = 3'b101; PED_L = 1'b1;
    #2 RESET = 1'b0;
    #1 chk("async_rst", 32'(dut_vec()), 32'(RESET_VEC));
    model_reset();
    @(negedge CLK);
    chk("rst_hold", 32'(dut_vec()), 32'(RESET_VEC));
    RESET = 1'b1;
    repeat (20) cycle(1, 3'b000, 0, 0, "post_rst");
    chk("post_rst_phase", 32'(PHASE), 32'd0);

    for (int i = 0; i < 1500; i++) begin
      bit       en;
      bit [2:0] rq;
      en = ($urandom % 4) != 0;
      rq = (($urandom % 6) == 0) ? 3'($urandom) : 3'b000;
      cycle(en, rq, ($urandom % 20) == 0, ($urandom % 20) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlc_phase_scheduler.md
Name: tlc_phase_scheduler

Overview:
- Phase scheduler for the three-road intersection light set: road lights A/B/C (green/yellow/red/left), plus left and right pedestrian crossings (red/green).
- Latches vehicle demand per road and pedestrian buttons, grants roads round-robin, and inserts a pedestrian walk phase between road phases.
- Steps only on clock edges where ENABLE=1 and freezes otherwise; it drives the light outputs directly.

Parameters:
- L_TIME, 2, left-turn phase length in enabled ticks (≥1)
- G_TIME, 4, green phase length in enabled ticks (≥1)
- Y_TIME, 1, yellow phase length in enabled ticks (≥1)
- AR_TIME, 1, all-red clearance length in enabled ticks (≥1)
- P_TIME, 3, pedestrian walk length in enabled ticks (≥1)
- CW, 4, timer width; every *_TIME must be ≤ 2^CW

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset (0 = reset)
- ENABLE  in  1  tick qualifier; 0 freezes the state and timer
- REQ  in  3  vehicle demand; bit0=A, bit1=B, bit2=C; level or pulse
- PED_L, PED_R  in  1 each  pedestrian buttons
- GA,YA,RA,LA / GB,YB,RB,LB / GC,YC,RC,LC  out  1 each  road lights
- RL,GL,RR,GR  out  1 each  pedestrian red/green, left and right crossing
- PHASE  out  3  current state encoding (debug)

Behaviour:
- States and PHASE encoding: ALL_RED=0, LEFT=1, GREEN=2, YELLOW=3, PED=4. The register `cur` (2 bits) holds the served road: 0=A, 1=B, 2=C.
- Outputs are registered and are a pure function of state, cur and the latched pedestrian flags.
  - Road cur in LEFT: Lx=1 and Rx=1.
  - Road cur in GREEN: Gx=1.
  - Road cur in YELLOW: Yx=1.
  - Every other road, in every state: Rx=1 only.
  - In PED: GL=pl and GR=pr; RL=~GL and RR=~GR.
  - In all other states: RL=RR=1 and GL=GR=0.
- Reset (RESET=0, asynchronous) sets:
  - state=ALL_RED, cur=C (so the first grant goes to A), timer=AR_TIME-1
  - pend=000, pl=pr=0
  - RA=RB=RC=RL=RR=1; every other light 0; PHASE=0
- Demand latch, evaluated every cycle regardless of ENABLE:
  - pend[i] is set by REQ[i]=1; pl is set by PED_L=1; pr is set by PED_R=1.
  - pend[cur] clears on the cycle that enters LEFT. pl and pr clear on the cycle that leaves PED.
  - If set and clear happen in the same cycle, set wins.
- Timer:
  - Loaded with <STATE>_TIME-1 on every state entry.
  - Decrements only when ENABLE=1.
  - The transition fires when ENABLE=1 and timer==0, so each state lasts exactly <STATE>_TIME enabled ticks.
- Transitions:
  - LEFT→GREEN→YELLOW→ALL_RED.
  - ALL_RED at expiry:
    - If pl|pr → PED (pedestrian priority).
    - Else if pend≠0 → LEFT, with cur set to the first pending road after the old cur in order A→B→C→A.
    - Else remain in ALL_RED, reload the timer, keep cur.
  - PED at expiry → ALL_RED.
- A road with its own pend bit set is regranted only after the other pending roads have been served, which gives starvation-free round-robin.
- With ENABLE=0 for any number of cycles, state, timer and outputs hold unchanged; demand still latches.
- A RESET assertion in any state returns to the reset values immediately, without waiting for the next CLK edge.
- Invariant: at most one of Gx/Yx/Lx is set across all roads, and GL|GR=1 only while all Rx=1.

Optional Feature:
- TLC_PED_COUNTDOWN_EN:
  - Defined: adds output PED_CNT [CW-1:0]. In PED it equals the timer value (P_TIME-1 down to 0); in every other state it is 0. It resets to 0.
  - Undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package tlc_pkg:
  - state encoding constants ST_ALL_RED..ST_PED
  - road index constants RD_A/RD_B/RD_C
  - default time constants
- One natural sub-module, tlc_rr_pick: combinational round-robin selector with inputs pend[2:0] and cur, and outputs next_cur and any.

Test Plan:
1. RESET=0 mid-GREEN of B (asynchronously) → RA=RB=RC=RL=RR=1, PHASE=0 immediately; after release with no demand, PHASE stays 0 for 20 enabled ticks.
2. REQ=001 pulse, ENABLE=1, defaults → after 1 AR tick: LA&RA for 2 ticks, GA for 4, YA for 1, then ALL_RED; pend clears.
3. REQ=111 held constantly → grant order A,B,C,A,B; each cycle is 8 enabled ticks (2+4+1+1).
4. PED_R pulse during A's GREEN → after YELLOW then ALL_RED: PHASE=4, GR=1, RL=1 for 3 ticks; pr clears; then the next pending road is granted.
5. ENABLE toggled 1 tick on / 1 tick off during LEFT → LEFT lasts 2 enabled ticks (4 clocks); outputs stable during the off ticks; REQ pulse while disabled is still latched.
6. With TLC_PED_COUNTDOWN_EN and PED_L → PED_CNT shows 2,1,0 during PED and 0 elsewhere.
